// File: rtl/limb_add_seq.sv
// -----------------------------------------------------------------------------
// limb_add_seq
//
// Sequential multi-precision adder front end. Operand pairs arrive one
// WIDTH-bit limb per cycle on a valid/ready stream, least-significant limb
// first. The carry is held in a register between limbs. Each accepted limb
// produces one registered sum limb a cycle later. The final limb of a
// transaction also carries the transaction carry-out.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   limb pair present
//   in_ready   out  block can accept a limb this cycle
//   in_a       in   operand A limb [WIDTH]
//   in_b       in   operand B limb [WIDTH]
//   in_cin     in   carry-in, used only on a limb treated as first
//   in_first   in   least-significant limb of a transaction
//   in_last    in   most-significant limb of a transaction
//   out_valid  out  out_sum holds a result limb
//   out_ready  in   downstream accepts result
//   out_sum    out  sum limb [WIDTH]
//   out_last   out  result limb closes its transaction
//   out_cout   out  transaction carry-out (0 unless out_last)
//   err        out  sticky protocol error flag
//   err_clr    in   clears err
// -----------------------------------------------------------------------------
module limb_add_seq #(
    parameter int WIDTH     = 26,
    parameter int MAX_LIMBS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic             err,
    input  logic             err_clr
);

    localparam int CNT_W = $clog2(MAX_LIMBS + 1);
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(MAX_LIMBS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] limb_cnt, limb_cnt_nxt;
    logic             carry_q;

    logic             accept;
    logic             xfer;
    logic             start;
    logic             err_set;
    logic             eff_last;
    logic             cin_eff;
    logic [WIDTH:0]   add_res;

    // Unsigned WIDTH+1 bit add: {carry, sum} = a + b + cin.
    function automatic logic [WIDTH:0] add_limb(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    // Single output register with no skid buffer: accept only when the
    // register is empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            limb_cnt <= '0;
        end else begin
            state    <= state_nxt;
            limb_cnt <= limb_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        limb_cnt_nxt = limb_cnt;
        start        = 1'b0;
        err_set      = 1'b0;
        eff_last     = in_last;
        if (accept) begin
            if (state == IDLE || in_first) begin
                // Any limb seen in IDLE, or a restart while BUSY, opens a
                // new transaction; a missing or unexpected in_first is flagged
                // but the limb is still processed as a first limb.
                start   = 1'b1;
                err_set = (state == IDLE) ? !in_first : 1'b1;
                if (in_last) begin
                    state_nxt    = IDLE;
                    limb_cnt_nxt = '0;
                end else begin
                    state_nxt    = BUSY;
                    limb_cnt_nxt = CNT_W'(1);
                end
            end else if (in_last) begin
                state_nxt    = IDLE;
                limb_cnt_nxt = '0;
            end else if (limb_cnt == CNT_FINAL) begin
                // Transaction would exceed MAX_LIMBS: close it here.
                err_set      = 1'b1;
                eff_last     = 1'b1;
                state_nxt    = IDLE;
                limb_cnt_nxt = '0;
            end else begin
                limb_cnt_nxt = limb_cnt + CNT_W'(1);
            end
        end
    end

    assign cin_eff = start ? in_cin : carry_q;
    assign add_res = add_limb(in_a, in_b, cin_eff);

    // Output stage: registered sum limb, flags and inter-limb carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            carry_q   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= add_res[WIDTH-1:0];
            out_last  <= eff_last;
            out_cout  <= eff_last ? add_res[WIDTH] : 1'b0;
            carry_q   <= add_res[WIDTH];
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // A new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_limb_add_seq.sv
// -----------------------------------------------------------------------------
// tb_limb_add_seq
//
// Directed and randomized stimulus for limb_add_seq. A reference model tracks
// the open transaction as "limbs seen so far" plus the running carry and
// predicts the output registers, in_ready and err for every cycle.
// -----------------------------------------------------------------------------
module tb_limb_add_seq;

    localparam int W    = 26;
    localparam int MAXL = 4;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_first;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_last;
    logic         out_cout;
    logic         err;
    logic         err_clr;

    limb_add_seq #(.WIDTH(W), .MAX_LIMBS(MAXL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_first (in_first),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_last (out_last),
        .out_cout (out_cout),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    logic         m_valid = 1'b0;
    logic [W-1:0] m_sum   = '0;
    logic         m_last  = 1'b0;
    logic         m_cout  = 1'b0;
    logic         m_err   = 1'b0;
    int           m_open  = 0;     // limbs already accepted in the open transaction
    logic         m_carry = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check in_ready mid-cycle, then check all
    // registered outputs after the edge against the model.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic first, input logic last,
                        input logic ordy, input logic clr, input logic rstn);
        logic        exp_ready;
        logic        acc;
        logic        new_err;
        logic        treat_first;
        logic        cin_use;
        logic        closes;
        longint      total;
        int          n;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_first  = first;
        in_last   = last;
        out_ready = ordy;
        err_clr   = clr;
        rst_n     = rstn;
        @(negedge clk);
        exp_ready = !m_valid || ordy;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        if (!rstn) begin
            m_valid = 0; m_sum = '0; m_last = 0; m_cout = 0; m_err = 0;
            m_open = 0; m_carry = 0;
        end else begin
            new_err = 1'b0;
            if (acc) begin
                treat_first = (m_open == 0) || first;
                if (first != (m_open == 0)) new_err = 1'b1;
                cin_use = treat_first ? cin : m_carry;
                total   = longint'(a) + longint'(b) + longint'(cin_use);
                n       = treat_first ? 1 : m_open + 1;
                closes  = last;
                if (!last && n == MAXL) begin
                    closes  = 1'b1;
                    new_err = 1'b1;
                end
                m_valid = 1'b1;
                m_sum   = W'(total);
                m_carry = (total >> W) != 0;
                m_last  = closes;
                m_cout  = closes ? m_carry : 1'b0;
                m_open  = closes ? 0 : n;
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
            if (new_err)   m_err = 1'b1;
            else if (clr)  m_err = 1'b0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_sum",   32'(out_sum),   32'(m_sum));
        chk("out_last",  32'(out_last),  32'(m_last));
        chk("out_cout",  32'(out_cout),  32'(m_cout));
        chk("err",       32'(err),       32'(m_err));
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset
        step(1'b0, '0, '0, 0, 0, 0, 1, 0, 1'b0);
        step(1'b0, '0, '0, 0, 0, 0, 1, 0, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err",   32'(err),       32'd0);

        // 1. Single limb with carry-out
        step(1, ONES, 26'h1, 0, 1, 1, 1, 0, 1);
        chk("t1_sum",  32'(out_sum),  32'h0);
        chk("t1_last", 32'(out_last), 32'd1);
        chk("t1_cout", 32'(out_cout), 32'd1);
        idle(1);

        // 2. Three limbs back-to-back
        step(1, ONES, 26'h1, 0, 1, 0, 1, 0, 1);
        chk("t2_sum0", 32'(out_sum), 32'h0);
        step(1, ONES, 26'h0, 0, 0, 0, 1, 0, 1);
        chk("t2_sum1", 32'(out_sum), 32'h0);
        chk("t2_last1", 32'(out_last), 32'd0);
        step(1, 26'h0, 26'h0, 0, 0, 1, 1, 0, 1);
        chk("t2_sum2", 32'(out_sum), 32'h1);
        chk("t2_last2", 32'(out_last), 32'd1);
        chk("t2_cout", 32'(out_cout), 32'd0);
        idle(1);

        // 3. Same add with 3 cycles of backpressure before limb 2
        step(1, ONES, 26'h1, 0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, ONES, 26'h0, 0, 0, 0, 0, 0, 1);
            chk("t3_hold_sum", 32'(out_sum), 32'h0);
            chk("t3_hold_rdy", 32'(in_ready), 32'd0);
        end
        step(1, ONES, 26'h0, 0, 0, 0, 1, 0, 1);
        chk("t3_sum1", 32'(out_sum), 32'h0);
        step(1, 26'h0, 26'h0, 0, 0, 1, 1, 0, 1);
        chk("t3_sum2", 32'(out_sum), 32'h1);
        chk("t3_last2", 32'(out_last), 32'd1);
        idle(1);

        // 4. Protocol errors
        step(1, 26'h10, 26'h20, 0, 1, 0, 1, 0, 1);
        step(1, 26'h1, 26'h1, 1, 1, 1, 1, 0, 1);     // restart mid-transaction
        chk("t4_restart_err", 32'(err), 32'd1);
        chk("t4_restart_sum", 32'(out_sum), 32'h3);
        step(1'b0, '0, '0, 0, 0, 0, 1, 1, 1);          // err_clr
        chk("t4_clr", 32'(err), 32'd0);
        step(1, 26'h2, 26'h2, 1, 0, 1, 1, 0, 1);     // IDLE limb without first
        chk("t4_nofirst_err", 32'(err), 32'd1);
        chk("t4_nofirst_sum", 32'(out_sum), 32'h5);
        step(1'b0, '0, '0, 0, 0, 0, 1, 1, 1);
        step(1, 26'h2, 26'h2, 0, 0, 1, 1, 1, 1);     // clear and new error together
        chk("t4_clr_vs_set", 32'(err), 32'd1);
        step(1'b0, '0, '0, 0, 0, 0, 1, 1, 1);
        chk("t4_clr2", 32'(err), 32'd0);

        // 5. Overflow after MAX_LIMBS limbs without in_last
        for (int i = 0; i < MAXL; i++)
            step(1, 26'h2000000, 26'h2000000, 0, (i == 0), 0, 1, 0, 1);
        chk("t5_last", 32'(out_last), 32'd1);
        chk("t5_cout", 32'(out_cout), 32'd1);
        chk("t5_err",  32'(err),      32'd1);
        step(1, 26'h1, 26'h1, 0, 1, 1, 1, 0, 1);
        chk("t5_next_sum", 32'(out_sum), 32'h2);
        idle(1);

        // 6. Reset mid-transaction
        step(1, ONES, ONES, 1, 1, 0, 0, 0, 1);
        step(1'b0, '0, '0, 0, 0, 0, 0, 0, 1'b0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        step(1, 26'd5, 26'd7, 0, 1, 1, 1, 0, 1);
        chk("t6_sum", 32'(out_sum), 32'd12);
        chk("t6_cout", 32'(out_cout), 32'd0);

        // Wrap-around: all-ones limbs with cin=1 carry through every limb
        step(1, ONES, ONES, 1, 1, 0, 1, 0, 1);
        step(1, ONES, ONES, 0, 0, 0, 1, 0, 1);
        step(1, ONES, ONES, 0, 0, 1, 1, 0, 1);
        chk("wrap_sum",  32'(out_sum),  32'(ONES));
        chk("wrap_cout", 32'(out_cout), 32'd1);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? ONES : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ONES : W'($urandom);
            step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 63) != 0);
        end
        idle(1);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/limb_add_seq.md
Name: limb_add_seq

Overview:
- Sequential multi-precision adder front end built around the team's 26-bit prefix adder datapath (sum = a + b + cin, with carry-out).
- Accepts one 26-bit limb pair per cycle on a valid/ready stream, least-significant limb first.
- Carries between limbs through a registered carry.
- Emits registered per-limb sums with a final carry-out, so operands wider than 26 bits are added over consecutive cycles.

Parameters:
- WIDTH, 26, limb width; must match the adder core.
- MAX_LIMBS, 4, maximum limbs per transaction; limb counter width = clog2(MAX_LIMBS+1).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset; synchronous, active-low
- in_valid  input  1  limb pair present
- in_ready  output  1  block can accept a limb this cycle
- in_a  input  WIDTH  operand A limb
- in_b  input  WIDTH  operand B limb
- in_cin  input  1  carry-in; sampled only on a first limb
- in_first  input  1  marks least-significant limb of a transaction
- in_last  input  1  marks most-significant limb of a transaction
- out_valid  output  1  out_sum holds a result limb
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  sum limb
- out_last  output  1  result limb is the last of its transaction
- out_cout  output  1  carry-out of the transaction; meaningful only when out_last=1, else 0
- err  output  1  sticky protocol error flag
- err_clr  input  1  clears err

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous, active-low.
- Reset values (rst_n=0 at a clock edge): out_valid=0, out_sum=0, out_last=0, out_cout=0, err=0, carry_q=0, limb_cnt=0, state=IDLE. Reset mid-transaction discards the transaction and any pending output limb.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single output register, no skid).
  - A limb is accepted when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - Latency from acceptance to out_valid is 1 cycle.
  - Throughput is one limb per cycle while out_ready=1.
- Datapath on accept:
  - cin_eff = in_cin if the limb is treated as first, else carry_q.
  - {c, s} = in_a + in_b + cin_eff, computed with WIDTH+1 bit arithmetic (unsigned).
  - Registers loaded: out_sum<=s, out_last<=in_last, out_cout<= in_last ? c : 0, out_valid<=1, carry_q<=c.
- If no accept and the output is transferred, out_valid<=0; the other output registers hold their values.
- State machine, IDLE / BUSY, advancing only on accept:
  - IDLE + in_first: treated as first. If in_last, stay IDLE; else go BUSY with limb_cnt=1.
  - IDLE + !in_first: protocol error. Set err; the limb is treated as first (cin_eff=in_cin). Transitions as above.
  - BUSY + !in_first: normal limb, limb_cnt++. If in_last, go IDLE and clear limb_cnt.
  - BUSY + in_first: protocol error. Set err; the previous transaction is abandoned (no out_last is ever produced for it). The limb starts a new transaction with in_cin; limb_cnt=1.
  - BUSY, limb_cnt==MAX_LIMBS-1, !in_last: overflow. The limb is processed, then set err, force out_last=1 and out_cout=c, and go IDLE.
- Single-limb transaction: in_first=in_last=1 behaves as a plain 26-bit add with cout.
- Wrap-around: all-ones limbs plus cin=1 propagate carry across every limb; the final out_cout=1.
- err: sticky until err_clr=1 at a clock edge. If err_clr and a new error occur in the same cycle, err ends at 1.
- Backpressure: while out_ready=0 and out_valid=1, all output registers and carry_q hold. in_ready=0 and no input is consumed.

Test Plan:
1. Single limb: a=0x3FFFFFF, b=0x0000001, cin=0, first=last=1 -> one cycle later out_sum=0x0000000, out_last=1, out_cout=1.
2. 3-limb add: A=limbs {0x3FFFFFF, 0x3FFFFFF, 0x0000000}, B=limbs {0x0000001, 0x0, 0x0}, cin=0, back-to-back -> sums 0x0, 0x0, 0x1 on consecutive cycles; out_cout=0; last flagged on limb 3 only.
3. Backpressure: hold out_ready=0 for 3 cycles during test 2, limb 2 -> in_ready=0, out_sum stays 0x0, no limb lost; the sequence completes identically after release.
4. Protocol errors:
   - Second in_first mid-transaction -> err=1, new transaction uses in_cin.
   - Limb in IDLE without in_first -> err=1.
   - err_clr -> err=0 next cycle.
5. Overflow: MAX_LIMBS=4, send 4 limbs with last=0, each a=b=0x2000000 -> 4th output has out_last=1, out_cout=1, err=1; the next limb with in_first starts cleanly.
6. Reset: assert rst_n=0 mid-transaction with out_valid=1 -> next cycle out_valid=0, carry_q=0, IDLE. Then a fresh single-limb 5+7 produces out_sum=12.
